// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// if_fetch_unit : PC owner, in-order I-mem fetch, credit-limited instr FIFO
// Revision      : 1.0
// ============================================================================
module if_fetch_unit #(
  parameter int unsigned          PC_WIDTH    = 64,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0,
  parameter int unsigned          DEPTH       = 4
) (
  input  logic                   p_clk,
  input  logic                   p_reset_l,
  output logic                   p_IMEM_ReqValid,
  output logic [PC_WIDTH-1:0]    p_IMEM_ReqAddr,
  input  logic                   p_IMEM_ReqReady,
  input  logic                   p_IMEM_RespValid,
  input  logic [INSTR_WIDTH-1:0] p_IMEM_RespData,
  input  logic                   p_Redirect,
  input  logic [PC_WIDTH-1:0]    p_RedirectPC,
  input  logic                   p_ID_Stall,
  output logic [INSTR_WIDTH-1:0] p_ID_IN_Instruction,
  output logic [PC_WIDTH-1:0]    p_IF_PC,
  output logic                   p_IF_Valid
);

  localparam int unsigned         CW      = $clog2(DEPTH + 1);
  localparam int unsigned         AW      = $clog2(DEPTH);
  localparam logic [CW:0]         DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]       FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0]       CNT_ONE = CW'(1);
  localparam logic [AW-1:0]       PTR_ONE = AW'(1);
  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]          inflight_q, inflight_d;
  logic [CW-1:0]          drop_q, drop_d;
  logic [CW-1:0]          count_q, count_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [PC_WIDTH-1:0]    pc_mem_q    [DEPTH];

  logic                   req_valid;
  logic                   req_fire;
  logic                   push;
  logic                   pop;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [PC_WIDTH-1:0]    redirect_pc;
  logic                   unused_redirect_lsbs;

  assign redirect_pc          = {p_RedirectPC[PC_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^p_RedirectPC[1:0];
  assign fifo_empty           = (count_q == '0);
  assign fifo_full            = (count_q == FULL_C);

  // Credit: buffered + outstanding words never exceed the FIFO size, so a
  // returning word always has a slot.
  assign req_valid = p_reset_l && !p_Redirect &&
                     (({1'b0, count_q} + {1'b0, inflight_q}) < DEPTH_C);
  assign req_fire  = req_valid && p_IMEM_ReqReady;
  assign push      = p_IMEM_RespValid && (drop_q == '0) && !p_Redirect;
  assign pop       = !fifo_empty && !p_ID_Stall && !p_Redirect;

  always_comb begin
    pc_d       = pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;

    if (req_fire) begin
      pc_d       = pc_q + PC_STEP;
      inflight_d = inflight_d + CNT_ONE;
    end
    if (p_IMEM_RespValid) begin
      inflight_d = inflight_d - CNT_ONE;
      if (drop_q != '0) drop_d = drop_q - CNT_ONE;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      rsp_pc_d = rsp_pc_q + PC_STEP;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Every word still outstanding after this edge belongs to an old path.
    if (p_Redirect) begin
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      drop_d   = inflight_d;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge p_clk or negedge p_reset_l) begin
    if (!p_reset_l) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge p_clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= p_IMEM_RespData;
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

  assign p_IMEM_ReqValid     = req_valid;
  assign p_IMEM_ReqAddr      = p_reset_l ? pc_q : '0;
  assign p_IF_Valid          = !fifo_empty;
  assign p_ID_IN_Instruction = fifo_empty ? '0 : instr_mem_q[rd_ptr_q];
  assign p_IF_PC             = fifo_empty ? '0 : pc_mem_q[rd_ptr_q];

  a_no_push_full: assert property (@(posedge p_clk) disable iff (!p_reset_l)
    push |-> !fifo_full);
  a_no_orphan_resp: assert property (@(posedge p_clk) disable iff (!p_reset_l)
    p_IMEM_RespValid |-> (inflight_q != '0));

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_if_fetch_unit : memory model + expected-stream checker for if_fetch_unit
// Revision         : 1.0
// ============================================================================
module tb_if_fetch_unit;
  localparam int unsigned DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h100;

  logic        p_clk = 1'b0;
  logic        p_reset_l = 1'b0;
  logic        p_IMEM_ReqValid;
  logic [63:0] p_IMEM_ReqAddr;
  logic        p_IMEM_ReqReady = 1'b0;
  logic        p_IMEM_RespValid = 1'b0;
  logic [31:0] p_IMEM_RespData = '0;
  logic        p_Redirect = 1'b0;
  logic [63:0] p_RedirectPC = '0;
  logic        p_ID_Stall = 1'b0;
  logic [31:0] p_ID_IN_Instruction;
  logic [63:0] p_IF_PC;
  logic        p_IF_Valid;

  always #5 p_clk = ~p_clk;

  if_fetch_unit #(.PC_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .p_clk(p_clk), .p_reset_l(p_reset_l),
    .p_IMEM_ReqValid(p_IMEM_ReqValid), .p_IMEM_ReqAddr(p_IMEM_ReqAddr),
    .p_IMEM_ReqReady(p_IMEM_ReqReady), .p_IMEM_RespValid(p_IMEM_RespValid),
    .p_IMEM_RespData(p_IMEM_RespData), .p_Redirect(p_Redirect),
    .p_RedirectPC(p_RedirectPC), .p_ID_Stall(p_ID_Stall),
    .p_ID_IN_Instruction(p_ID_IN_Instruction), .p_IF_PC(p_IF_PC), .p_IF_Valid(p_IF_Valid)
  );

  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct { logic [63:0] target; int lat; logic [63:0] exp0; logic [63:0] exp1; } tv_t;

  mreq_t       mq[$];
  tv_t         tv[4];
  int          cyc = 0, last_due = 0, cmp_cnt = 0, err_cnt = 0;
  int          lat_min = 1, lat_max = 1, rdy_pct = 100;
  logic        rst_drive = 1'b0;
  logic [63:0] req_pc, exp_pc;
  logic        after_redir = 0, hold_v = 0, prev_req_wait = 0;
  logic [63:0] hold_pc, prev_req_addr;
  logic [31:0] hold_instr;
  logic        popped, req_seen;
  logic [63:0] popped_pc, req_seen_addr;

  // Instruction memory contents: an address hash, so any wrong/stale word shows up.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] p;
    p = (a >> 2) * 64'h9E37_79B9_7F4A_7C15;
    return p[63:32] ^ a[31:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic reset_model();
    mq.delete();
    last_due      = cyc;
    req_pc        = RST_PC;
    exp_pc        = RST_PC;
    after_redir   = 0;
    hold_v        = 0;
    prev_req_wait = 0;
  endtask

  // One clock cycle: drive at negedge, settle, check, advance the model as of the next posedge.
  task automatic step(input logic stall, input logic redir, input logic [63:0] tgt);
    int d;
    @(negedge p_clk);
    cyc++;
    p_reset_l = rst_drive;
    if (rst_drive && mq.size() > 0 && mq[0].due <= cyc) begin
      p_IMEM_RespValid = 1'b1;
      p_IMEM_RespData  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      p_IMEM_RespValid = 1'b0;
      p_IMEM_RespData  = $urandom;
    end
    p_IMEM_ReqReady = ($urandom_range(0, 99) < rdy_pct);
    p_ID_Stall      = stall;
    p_Redirect      = redir;
    p_RedirectPC    = tgt;
    #1;
    popped   = 0;
    req_seen = 0;
    if (!rst_drive) begin
      chk("reset_reqvalid", 64'(p_IMEM_ReqValid), 64'd0);
      chk("reset_reqaddr", p_IMEM_ReqAddr, 64'd0);
      chk("reset_ifvalid", 64'(p_IF_Valid), 64'd0);
      chk("reset_instr", 64'(p_ID_IN_Instruction), 64'd0);
      chk("reset_ifpc", p_IF_PC, 64'd0);
      after_redir = 0; hold_v = 0; prev_req_wait = 0;
      return;
    end
    if (after_redir) chk("flush_after_redirect", 64'(p_IF_Valid), 64'd0);
    if (hold_v) begin
      chk("stall_hold_pc", p_IF_PC, hold_pc);
      chk("stall_hold_instr", 64'(p_ID_IN_Instruction), 64'(hold_instr));
    end
    if (prev_req_wait && !redir) begin
      chk("req_stable_valid", 64'(p_IMEM_ReqValid), 64'd1);
      chk("req_stable_addr", p_IMEM_ReqAddr, prev_req_addr);
    end
    if (redir) chk("no_req_on_redirect", 64'(p_IMEM_ReqValid), 64'd0);
    if (!p_IF_Valid) begin
      chk("empty_instr_zero", 64'(p_ID_IN_Instruction), 64'd0);
      chk("empty_pc_zero", p_IF_PC, 64'd0);
    end else if (!stall && !redir) begin
      chk("pop_pc", p_IF_PC, exp_pc);
      chk("pop_instr", 64'(p_ID_IN_Instruction), 64'(mem_word(exp_pc)));
      popped    = 1;
      popped_pc = p_IF_PC;
      exp_pc    = exp_pc + 64'd4;
    end
    if (p_IMEM_ReqValid && p_IMEM_ReqReady) begin
      chk("req_addr", p_IMEM_ReqAddr, req_pc);
      req_seen      = 1;
      req_seen_addr = p_IMEM_ReqAddr;
      d = cyc + $urandom_range(lat_min, lat_max);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr: p_IMEM_ReqAddr, due: d});
      req_pc = req_pc + 64'd4;
    end
    chk("credit_limit", 64'(mq.size() <= DEPTH), 64'd1);
    prev_req_wait = p_IMEM_ReqValid && !p_IMEM_ReqReady;
    prev_req_addr = p_IMEM_ReqAddr;
    after_redir   = redir;
    hold_v        = p_IF_Valid && stall && !redir;
    hold_pc       = p_IF_PC;
    hold_instr    = p_ID_IN_Instruction;
    if (redir) begin
      exp_pc = {tgt[63:2], 2'b00};
      req_pc = {tgt[63:2], 2'b00};
    end
  endtask

  initial begin
    int first_pop, npops, nreq;
    logic [63:0] pops[2], reqs[2], tgt;

    tv[0] = '{target: 64'h2003,                lat: 3, exp0: 64'h2000,                exp1: 64'h2004};
    tv[1] = '{target: 64'h4000_0001,           lat: 1, exp0: 64'h4000_0000,           exp1: 64'h4000_0004};
    tv[2] = '{target: 64'hFFFF_FFFF_FFFF_FFFE, lat: 2, exp0: 64'hFFFF_FFFF_FFFF_FFFC, exp1: 64'h0};
    tv[3] = '{target: 64'hABE,                 lat: 5, exp0: 64'hABC,                 exp1: 64'hAC0};

    reset_model();
    repeat (3) step(0, 0, '0);

    // Reset release with L=1: first fetch 0x100, first valid two edges later, then one per cycle.
    reset_model();
    rst_drive = 1;
    first_pop = -1; npops = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, '0);
      if (i == 0) begin
        chk("rst_first_req_seen", 64'(req_seen), 64'd1);
        chk("rst_first_req_addr", req_seen_addr, RST_PC);
      end
      if (popped) begin
        if (first_pop < 0) begin first_pop = i; pops[0] = popped_pc; end
        npops++;
      end
    end
    chk("rst_first_valid_latency", 64'(first_pop), 64'd2);
    chk("rst_first_pc", pops[0], RST_PC);
    chk("one_per_cycle", 64'(npops), 64'd10);

    // Long stall: output frozen, requests stop at the credit limit, stream resumes gap-free.
    repeat (10) step(1, 0, '0);
    chk("stall_reqvalid_low", 64'(p_IMEM_ReqValid), 64'd0);
    chk("stall_no_outstanding", 64'(mq.size()), 64'd0);
    npops = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, '0);
      if (popped) npops++;
    end
    chk("post_stall_stream", 64'(npops), 64'd8);

    // Redirect table: first two fetched and delivered PCs of the new path.
    for (int t = 0; t < 4; t++) begin
      lat_min = tv[t].lat; lat_max = tv[t].lat;
      repeat (6) step(0, 0, '0);
      step(0, 1, tv[t].target);
      npops = 0; nreq = 0;
      for (int i = 0; i < 40 && npops < 2; i++) begin
        step(0, 0, '0);
        if (i == 0) chk("tbl_flush", 64'(p_IF_Valid), 64'd0);
        if (req_seen && nreq < 2) begin reqs[nreq] = req_seen_addr; nreq++; end
        if (popped) begin pops[npops] = popped_pc; npops++; end
      end
      chk("tbl_pop_count", 64'(npops), 64'd2);
      chk("tbl_req0", (nreq > 0) ? reqs[0] : 64'hDEAD, tv[t].exp0);
      chk("tbl_req1", (nreq > 1) ? reqs[1] : 64'hDEAD, tv[t].exp1);
      chk("tbl_pop0", (npops > 0) ? pops[0] : 64'hDEAD, tv[t].exp0);
      chk("tbl_pop1", (npops > 1) ? pops[1] : 64'hDEAD, tv[t].exp1);
    end

    // Redirect coinciding with a response and a ready memory, then back-to-back redirects.
    lat_min = 1; lat_max = 1;
    repeat (6) step(0, 0, '0);
    step(0, 1, 64'h3000);
    repeat (4) step(0, 0, '0);
    lat_min = 3; lat_max = 3;
    repeat (6) step(0, 0, '0);
    step(0, 1, 64'h5000);
    step(0, 1, 64'h6004);
    first_pop = -1;
    for (int i = 0; i < 30 && first_pop < 0; i++) begin
      step(0, 0, '0);
      if (popped) begin first_pop = i; pops[0] = popped_pc; end
    end
    chk("b2b_redirect_last_target", (first_pop >= 0) ? pops[0] : 64'hDEAD, 64'h6004);

    // Randomized traffic against the expected-stream model.
    rdy_pct = 60; lat_min = 1; lat_max = 5; npops = 0;
    for (int i = 0; i < 2500; i++) begin
      logic redir;
      redir = ($urandom_range(0, 99) < 3);
      tgt   = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) tgt = {60'hFFFF_FFFF_FFFF_FFF, 4'($urandom)};
      step($urandom_range(0, 99) < 30, redir, tgt);
      if (popped) npops++;
    end
    chk("random_progress", 64'(npops > 300), 64'd1);

    // Asynchronous reset mid-burst.
    rdy_pct = 100; lat_min = 2; lat_max = 2;
    repeat (6) step(0, 0, '0);
    @(negedge p_clk);
    #3 p_reset_l = 1'b0;
    #1;
    chk("async_rst_reqvalid", 64'(p_IMEM_ReqValid), 64'd0);
    chk("async_rst_reqaddr", p_IMEM_ReqAddr, 64'd0);
    chk("async_rst_ifvalid", 64'(p_IF_Valid), 64'd0);
    chk("async_rst_instr", 64'(p_ID_IN_Instruction), 64'd0);
    chk("async_rst_ifpc", p_IF_PC, 64'd0);
    rst_drive = 0;
    reset_model();
    repeat (2) step(0, 0, '0);
    reset_model();
    rst_drive = 1;
    first_pop = -1;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, '0);
      if (i == 0) chk("restart_req_addr", req_seen ? req_seen_addr : 64'hDEAD, RST_PC);
      if (popped && first_pop < 0) begin first_pop = i; pops[0] = popped_pc; end
    end
    chk("restart_first_pc", (first_pop >= 0) ? pops[0] : 64'hDEAD, RST_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
